rx_ctl_os: RTL and testbench
============================

// Module: rx_ctl_os
// PURPOSE
//  UART receive controller, the receive-side counterpart of the existing TX controller. Recovers 8N1 frames
//  (start, 8 data bits LSB first, 1 stop) from the serial input pin using 16x oversampling and writes each
//  good byte into the RX buffer with a one-cycle write strobe. Sits between the pin and the RX FIFO; the
//  oversample tick comes from the shared baud generator.
// PARAMETERS
//  OVERSAMPLE  16  rx_tick pulses per bit; even, >=8; sample points OVERSAMPLE/2-1, /2, /2+1
//  DATA_BITS   8   data bits per frame; rx_data width
// PORTS
//  clk            in   1          system clock; all logic on posedge
//  rst_n          in   1          asynchronous, active-low reset
//  rx_tick        in   1          1-clk pulse at OVERSAMPLE x baud; state advances only when high
//  rx_pin_in      in   1          raw serial line, asynchronous, idle high
//  rx_buf_full    in   1          RX buffer cannot accept a write this cycle
//  rx_data        out  DATA_BITS  last good byte; stable from rx_write_buf until next write
//  rx_write_buf   out  1          1-clk write strobe to RX buffer
//  rx_band_sig    out  1          high while a frame is being received
//  rx_frame_err   out  1          1-clk pulse: stop bit sampled low
//  rx_overrun     out  1          1-clk pulse: good byte dropped because rx_buf_full
// BEHAVIOUR
//  Reset: rx_data=0, rx_write_buf=0, rx_band_sig=0, rx_frame_err=0, rx_overrun=0; state IDLE; sync FFs=1.
//  Input: 2-FF synchronizer on rx_pin_in (reset value 1); all decisions use synchronized value.
//  Sampling: per-bit tick counter cnt 0..OVERSAMPLE-1; samples taken at cnt=OVERSAMPLE/2-1, /2, /2+1;
//   bit value = majority of the 3; decision made on the tick at cnt=OVERSAMPLE/2+1.
//  States:
//   IDLE  - on rx_tick with line low: cnt<=0, rx_band_sig<=1, -> START.
//   START - at decision: majority 1 => false start, rx_band_sig<=0, -> IDLE, no strobe;
//           majority 0 => continue; at cnt=OVERSAMPLE-1 -> DATA, bitidx<=0, cnt<=0.
//   DATA  - at decision: shift bit into shreg MSB side (LSB-first line order); at cnt=OVERSAMPLE-1:
//           bitidx==DATA_BITS-1 -> STOP else bitidx++; cnt<=0.
//   STOP  - at decision (mid stop bit, no wait for bit end):
//           1 & !rx_buf_full -> rx_data<=shreg, rx_write_buf<=1, -> IDLE;
//           1 &  rx_buf_full -> rx_overrun<=1, rx_data unchanged, -> IDLE;
//           0                -> rx_frame_err<=1, -> BREAK. rx_band_sig<=0 on exit to IDLE.
//   BREAK - wait for synchronized line high on an rx_tick, then rx_band_sig<=0, -> IDLE; prevents a
//           held-low line/break being decoded as a stream of 0x00 frames.
//  Latency: strobes are registered, asserted the clk after the deciding rx_tick; pulses last exactly 1 clk.
//  Back-to-back frames: leaving STOP at mid-bit gives OVERSAMPLE/2-1 ticks margin to catch next start edge.
//  rx_tick gaps: counters/state hold when rx_tick low; rx_pin changes between ticks ignored.
//  rx_buf_full sampled only in the strobe cycle; no retry, no stall of reception.
//  Reset mid-frame: immediate return to reset values; partial byte discarded, no strobe.
//  Widths: cnt $clog2(OVERSAMPLE) bits, bitidx $clog2(DATA_BITS) bits, no wrap beyond stated terminal counts.
// STRUCTURE
//  Shared package uart_pkg: state encodings (IDLE, START, DATA, STOP, BREAK as localparams), default
//   OVERSAMPLE and DATA_BITS; TX side uses the same package for DATA_BITS.
//  One sub-module: uart_rx_sampler (2-FF synchronizer + 3-sample majority vote, outputs line_sync and
//   bit_val/bit_valid at the decision tick). FSM, counters, shift register and strobes in rx_ctl_os.
// TESTING (rx_tick every 4 clk, OVERSAMPLE=16)
//  Frame 0x55 with clean edges -> one rx_write_buf pulse, rx_data=0x55, no err/overrun, band low after.
//  0xA5 then 0x3C with zero idle between frames -> two strobes, data 0xA5 then 0x3C in order.
//  Line low for 4 ticks then high (glitch) -> no strobe, rx_band_sig returns to 0, state IDLE.
//  Frame 0x81 with stop bit low, line held low 40 ticks -> one rx_frame_err pulse, no strobe, no further
//   frames until line high; next 0x42 frame received correctly.
//  rx_buf_full=1 during frame 0x7E -> rx_overrun pulse, no strobe, rx_data keeps previous value.
//  rst_n low during DATA bit 4 of 0xFF, release, send 0x12 -> only 0x12 strobed; outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, default frame geometry
// and the 3-sample majority helper used by the RX sampler.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_START_ENC = 3'd1;
  localparam logic [2:0] ST_DATA_ENC  = 3'd2;
  localparam logic [2:0] ST_STOP_ENC  = 3'd3;
  localparam logic [2:0] ST_BREAK_ENC = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE_ENC,
    START = ST_START_ENC,
    DATA  = ST_DATA_ENC,
    STOP  = ST_STOP_ENC,
    BREAK = ST_BREAK_ENC
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line front end: 2-FF synchronizer for the asynchronous pin and a
// 3-point majority vote around the middle of each bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  localparam int CW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_tick,
  input  logic          rx_pin_in,
  input  logic          sample_en,
  input  logic [CW-1:0] cnt,
  output logic          line_sync,
  output logic          bit_val,
  output logic          bit_valid
);

  localparam logic [CW-1:0] SAMPLE_A = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMPLE_B = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SAMPLE_C = CW'(OVERSAMPLE / 2 + 1);

  logic [1:0] sync_q;
  logic       samp_a_q;
  logic       samp_b_q;

  // Two-stage synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_pin_in};
    end
  end

  assign line_sync = sync_q[1];

  // Capture the first two votes; the third is the live value at the decision tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else if (rx_tick && sample_en) begin
      if (cnt == SAMPLE_A) samp_a_q <= line_sync;
      if (cnt == SAMPLE_B) samp_b_q <= line_sync;
    end
  end

  assign bit_valid = rx_tick && sample_en && (cnt == SAMPLE_C);
  assign bit_val   = majority3(samp_a_q, samp_b_q, line_sync);

endmodule

// File: rtl/rx_ctl_os.sv
// UART 8N1 receive controller with 16x oversampling. Decodes frames from the
// serial pin and writes each good byte into the RX buffer with a 1-clk strobe.
module rx_ctl_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx_pin_in,
  input  logic                 rx_buf_full,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_write_buf,
  output logic                 rx_band_sig,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 write_d, band_d, ferr_d, ovr_d;

  logic line_sync;
  logic bit_val;
  logic bit_valid;
  logic sample_en;

  assign sample_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_tick  (rx_tick),
    .rx_pin_in(rx_pin_in),
    .sample_en(sample_en),
    .cnt      (cnt_q),
    .line_sync(line_sync),
    .bit_val  (bit_val),
    .bit_valid(bit_valid)
  );

  // State, counters, shift register and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitidx_q     <= '0;
      shreg_q      <= '0;
      rx_data      <= '0;
      rx_write_buf <= 1'b0;
      rx_band_sig  <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitidx_q     <= bitidx_d;
      shreg_q      <= shreg_d;
      rx_data      <= data_d;
      rx_write_buf <= write_d;
      rx_band_sig  <= band_d;
      rx_frame_err <= ferr_d;
      rx_overrun   <= ovr_d;
    end
  end

  // Next-state logic; everything holds between oversample ticks and strobes default low
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    data_d   = rx_data;
    write_d  = 1'b0;
    band_d   = rx_band_sig;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (rx_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!line_sync) begin
            cnt_d   = '0;
            band_d  = 1'b1;
            state_d = START;
          end
        end

        START: begin
          if (bit_valid && bit_val) begin
            band_d  = 1'b0;
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            bitidx_d = '0;
            state_d  = DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (bit_valid) begin
            shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bitidx_q == IDX_LAST) begin
              state_d = STOP;
            end else begin
              bitidx_d = bitidx_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (bit_valid) begin
            if (bit_val) begin
              if (rx_buf_full) begin
                ovr_d = 1'b1;
              end else begin
                data_d  = shreg_q;
                write_d = 1'b1;
              end
              band_d  = 1'b0;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        BREAK: begin
          if (line_sync) begin
            band_d  = 1'b0;
            state_d = IDLE;
          end
        end

        default: begin
          band_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctl_os.sv
// Self-checking bench for rx_ctl_os: table-driven frames plus hand-written
// sequences for back-to-back frames, glitches, breaks and mid-frame reset.
module tb_rx_ctl_os;

  logic       clk;
  logic       rst_n;
  logic       rx_tick;
  logic       rx_pin_in;
  logic       rx_buf_full;
  logic [7:0] rx_data;
  logic       rx_write_buf;
  logic       rx_band_sig;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int wr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, strobe_err = 0;
  int base_wr, base_ferr, base_ovr;
  logic [7:0] last_wr;
  logic [7:0] wr_log[$];
  logic prev_wr = 0, prev_ferr = 0, prev_ovr = 0;
  int tick_div = 0;

  typedef struct {
    logic [7:0] frame;
    logic       stop_bit;
    logic       buf_full;
    int         exp_wr;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[4];

  rx_ctl_os #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_tick     (rx_tick),
    .rx_pin_in   (rx_pin_in),
    .rx_buf_full (rx_buf_full),
    .rx_data     (rx_data),
    .rx_write_buf(rx_write_buf),
    .rx_band_sig (rx_band_sig),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample tick: one clk out of every four
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    rx_tick  = (tick_div == 0);
  end

  // Count strobes; each must be one clk wide and follow a tick-qualified edge
  always @(posedge clk) begin
    #1;
    if (rx_write_buf) begin
      wr_cnt++;
      last_wr = rx_data;
      wr_log.push_back(rx_data);
      if (!rx_tick || prev_wr) strobe_err++;
    end
    if (rx_frame_err) begin
      ferr_cnt++;
      if (!rx_tick || prev_ferr) strobe_err++;
    end
    if (rx_overrun) begin
      ovr_cnt++;
      if (!rx_tick || prev_ovr) strobe_err++;
    end
    prev_wr   = rx_write_buf;
    prev_ferr = rx_frame_err;
    prev_ovr  = rx_overrun;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic mark_base();
    base_wr   = wr_cnt;
    base_ferr = ferr_cnt;
    base_ovr  = ovr_cnt;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
    rx_pin_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = d[i];
      wait_ticks(16);
    end
    rx_pin_in = stop;
    wait_ticks(16);
    if (!stop && extra_low > 0) wait_ticks(extra_low);
    rx_pin_in = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    mark_base();
    rx_buf_full = v.buf_full;
    send_frame(v.frame, v.stop_bit, 0);
    rx_buf_full = 1'b0;
    wait_ticks(4);
  endtask

  task automatic checkOutput(input string name, input int exp_wr, input logic [7:0] exp_data,
                             input int exp_ferr, input int exp_ovr);
    check({name, " writes"}, wr_cnt - base_wr, exp_wr);
    check({name, " rx_data"}, int'(rx_data), int'(exp_data));
    check({name, " frame_err"}, ferr_cnt - base_ferr, exp_ferr);
    check({name, " overrun"}, ovr_cnt - base_ovr, exp_ovr);
    check({name, " band_low"}, int'(rx_band_sig), 0);
    if (exp_wr > 0) check({name, " written"}, int'(last_wr), int'(exp_data));
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 0, 0};
    vecs[1] = '{8'h7E, 1'b1, 1'b1, 0, 8'h55, 0, 1};
    vecs[2] = '{8'h0F, 1'b0, 1'b0, 0, 8'h55, 1, 0};
    vecs[3] = '{8'hC3, 1'b1, 1'b0, 1, 8'hC3, 0, 0};

    rst_n       = 1'b0;
    rx_pin_in   = 1'b1;
    rx_buf_full = 1'b0;
    rx_tick     = 1'b0;
    repeat (5) @(negedge clk);
    check("reset rx_data", int'(rx_data), 0);
    check("reset write", int'(rx_write_buf), 0);
    check("reset band", int'(rx_band_sig), 0);
    check("reset ferr", int'(rx_frame_err), 0);
    check("reset ovr", int'(rx_overrun), 0);
    rst_n = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_data,
                  vecs[i].exp_ferr, vecs[i].exp_ovr);
    end

    // Back-to-back frames with no idle gap
    mark_base();
    wr_log.delete();
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    wait_ticks(4);
    check("b2b writes", wr_cnt - base_wr, 2);
    if (wr_log.size() == 2) begin
      check("b2b first", int'(wr_log[0]), 'hA5);
      check("b2b second", int'(wr_log[1]), 'h3C);
    end else begin
      check("b2b log size", wr_log.size(), 2);
    end

    // Four-tick low glitch must be rejected as a false start
    mark_base();
    rx_pin_in = 1'b0;
    wait_ticks(4);
    check("glitch band high", int'(rx_band_sig), 1);
    rx_pin_in = 1'b1;
    wait_ticks(30);
    check("glitch writes", wr_cnt - base_wr, 0);
    check("glitch band low", int'(rx_band_sig), 0);
    check("glitch ferr", ferr_cnt - base_ferr, 0);

    // Low stop bit followed by a long break, then a good frame
    mark_base();
    rx_pin_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = (i == 0 || i == 7);
      wait_ticks(16);
    end
    rx_pin_in = 1'b0;
    wait_ticks(16 + 40);
    check("break ferr", ferr_cnt - base_ferr, 1);
    check("break writes", wr_cnt - base_wr, 0);
    check("break band held", int'(rx_band_sig), 1);
    rx_pin_in = 1'b1;
    wait_ticks(8);
    check("break band low", int'(rx_band_sig), 0);
    mark_base();
    send_frame(8'h42, 1'b1, 0);
    wait_ticks(4);
    check("after break writes", wr_cnt - base_wr, 1);
    check("after break data", int'(last_wr), 'h42);

    // Reset in the middle of data bit 4 of 0xFF
    mark_base();
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        wait_ticks(16 + 4 * 16 + 8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset rx_data", int'(rx_data), 0);
        check("midreset band", int'(rx_band_sig), 0);
        check("midreset write", int'(rx_write_buf), 0);
        rst_n = 1'b1;
      end
    join
    wait_ticks(4);
    check("midreset no strobe", wr_cnt - base_wr, 0);
    check("midreset no ferr", ferr_cnt - base_ferr, 0);
    mark_base();
    send_frame(8'h12, 1'b1, 0);
    wait_ticks(4);
    check("post reset writes", wr_cnt - base_wr, 1);
    check("post reset data", int'(rx_data), 'h12);

    check("strobe shape", strobe_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
